function_mode_sequencer: RTL and testbench
==========================================

# function_mode_sequencer

Parametrised successor to the fixed three-function mode selector at the top of the keyboard interface. It owns the active-function index for `NUM_FUNCS` function controllers and steps forward and backward on debounced button edges. Functions that are unavailable are skipped, and a short mode banner is shown after every switch. It produces a one-hot enable per controller, routes keyboard pulses only to the active controller, and multiplexes each controller's display word and LED word onto the SSD controller and LED outputs.

## Interface
Parameters:
- `NUM_FUNCS`, 3: number of function controllers, 2..16.
- `DISP_W`, 32: width of one function's SSD word.
- `LED_W`, 16: width of one function's LED word; must be ≥ `NUM_FUNCS`.
- `KEY_W`, 8: keyboard scan-code width.
- `BANNER_CYCLES`, 50_000_000: banner duration in clk cycles; 0 disables the banner.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `nextFunc`, in, 1: single-cycle edge pulse that requests the next function.
- `prevFunc`, in, 1: single-cycle edge pulse that requests the previous function.
- `funcAvail`, in, `NUM_FUNCS`: bit i set means function i is selectable.
- `keyPulse`, in, `KEY_W`: scan code, nonzero for one cycle per key press.
- `functionDisplays`, in, `NUM_FUNCS*DISP_W`: function i's word at `[i*DISP_W +: DISP_W]`.
- `functionLEDs`, in, `NUM_FUNCS*LED_W`: function i's word at `[i*LED_W +: LED_W]`.
- `mode`, out, `$clog2(NUM_FUNCS)`: active function index.
- `funcEnable`, out, `NUM_FUNCS`: one-hot enable for the active function.
- `funcKey`, out, `KEY_W`: `keyPulse` gated for the active function; zero otherwise.
- `modeChange`, out, 1: one-cycle pulse when `mode` takes a new value.
- `wordBus`, out, `DISP_W`: word sent to the SSD controller.
- `led`, out, `LED_W`: LED word.

## Operation
The block has three states: ACTIVE, SEARCH and BANNER.

Reset:
- `mode`=0, state=SEARCH, candidate=0, dir=forward.
- All outputs are 0.
- The first search validates function 0.

ACTIVE:
- `funcEnable` = one-hot(`mode`).
- `funcKey` = `keyPulse`.
- `wordBus`/`led` = slice `mode` of `functionDisplays`/`functionLEDs`.
- `nextFunc` alone: go to SEARCH, candidate = (`mode`+1) mod `NUM_FUNCS`.
- `prevFunc` alone: go to SEARCH, candidate = (`mode`-1) mod `NUM_FUNCS`.
- `nextFunc` and `prevFunc` together: ignored.
- `funcAvail[mode]` deasserted: forced forward search, as if `nextFunc` were pulsed.

SEARCH examines one candidate per cycle:
- `funcAvail[cand]`=1 and cand≠`mode`: `mode`←cand, `modeChange`=1, go to BANNER, counter ← `BANNER_CYCLES`-1. When `BANNER_CYCLES`=0, go to ACTIVE instead.
- `funcAvail[cand]`=1 and cand=`mode` (full wrap, or reset validation of 0): go to ACTIVE with no `modeChange`.
- `funcAvail[cand]`=0 and cand=`mode`: no other function is available. Stay in SEARCH and rescan continuously; `funcEnable` stays 0.
- Otherwise: cand ← cand±1 mod `NUM_FUNCS` in the current direction.
- `nextFunc`/`prevFunc` are ignored in SEARCH.

BANNER:
- `funcEnable`=0 and `funcKey`=0. Keys pressed during the banner are dropped.
- `wordBus` = `mode` zero-extended to `DISP_W`.
- `led` = one-hot(`mode`) zero-extended to `LED_W`.
- The counter decrements each cycle; at 0 go to ACTIVE.
- `nextFunc`/`prevFunc` are accepted and restart SEARCH from the current `mode`.
- The banner counter width is `$clog2(BANNER_CYCLES+1)`.

General rules:
- `mode` never holds a value ≥ `NUM_FUNCS`.
- Wrap-around is modular in both directions.
- `rst` asserted mid-search or mid-banner returns the block immediately to the reset state.

## Timing
- All state, `mode`, `funcEnable` and `modeChange` are registered.
- `funcKey`, `wordBus` and `led` are combinational from registered state plus inputs, so a key pulse reaches the active controller in the same cycle.
- Request latency: a request sampled at edge t makes `mode` update at edge t+1+k, where k is the number of unavailable functions skipped. `modeChange` is high during cycle t+1+k.
- Banner length: BANNER lasts exactly `BANNER_CYCLES` cycles. `funcEnable` is nonzero again from edge t+1+k+`BANNER_CYCLES`.
- After reset release, with function 0 available, `funcEnable`=0001 after 1 edge.

## Test plan
Benches run with `NUM_FUNCS`=4, `BANNER_CYCLES`=4, `funcAvail`=1111.
- Reset and wrap: release reset.
  - Required: `mode`=0 and `funcEnable`=0001 after 1 cycle.
  - Then pulse `nextFunc` 4 times, waiting for ACTIVE each time. Required: `mode` sequence 1,2,3,0, exactly 4 `modeChange` pulses, `wordBus`=mode during each 4-cycle banner.
- Reverse wrap: `prevFunc` from `mode`=0.
  - Required: `mode`=3 two cycles after the pulse.
  - Required: `led`=1000 during the banner, then `led`=`functionLEDs[63:48]`.
- Skip: `funcAvail`=1011, `mode`=1, pulse `nextFunc`.
  - Required: `mode`=3 after 3 cycles; function 2 is never enabled.
- Key gating: `mode`=2 ACTIVE, `keyPulse`=8'h1C.
  - Required: `funcKey`=8'h1C the same cycle.
  - Repeat during BANNER. Required: `funcKey`=0 and `funcEnable`=0.
- Edge cases:
  - `nextFunc`&`prevFunc` simultaneously: no state change.
  - Drop `funcAvail[mode]` in ACTIVE: forward search to the next available function.
  - `funcAvail`=0000: `funcEnable` stays 0, no `modeChange`.
- Mid-operation reset: assert `rst` during BANNER. Required: all outputs 0 immediately, then normal restart.

Source files
------------

// File: rtl/function_mode_sequencer_if.sv
// Signal bundle between the keyboard front end, the function controllers and the
// function mode sequencer.
interface function_mode_sequencer_if #(
  parameter int unsigned NUM_FUNCS = 3,
  parameter int unsigned DISP_W    = 32,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned KEY_W     = 8
);
  localparam int unsigned MODE_W = $clog2(NUM_FUNCS);

  logic                        nextFunc;
  logic                        prevFunc;
  logic [NUM_FUNCS-1:0]        funcAvail;
  logic [KEY_W-1:0]            keyPulse;
  logic [NUM_FUNCS*DISP_W-1:0] functionDisplays;
  logic [NUM_FUNCS*LED_W-1:0]  functionLEDs;
  logic [MODE_W-1:0]           mode;
  logic [NUM_FUNCS-1:0]        funcEnable;
  logic [KEY_W-1:0]            funcKey;
  logic                        modeChange;
  logic [DISP_W-1:0]           wordBus;
  logic [LED_W-1:0]            led;

  modport master (
    output nextFunc, prevFunc, funcAvail, keyPulse, functionDisplays, functionLEDs,
    input  mode, funcEnable, funcKey, modeChange, wordBus, led
  );

  modport slave (
    input  nextFunc, prevFunc, funcAvail, keyPulse, functionDisplays, functionLEDs,
    output mode, funcEnable, funcKey, modeChange, wordBus, led
  );
endinterface

// File: rtl/function_mode_sequencer.sv
// Owns the active-function index: steps through available functions on button edges,
// shows a short mode banner after each switch and routes keys/display/LEDs to the active one.
module function_mode_sequencer #(
  parameter int unsigned NUM_FUNCS     = 3,
  parameter int unsigned DISP_W        = 32,
  parameter int unsigned LED_W         = 16,
  parameter int unsigned KEY_W         = 8,
  parameter int unsigned BANNER_CYCLES = 50_000_000
) (
  input logic                      clk,
  input logic                      rst,
  function_mode_sequencer_if.slave bus
);
  localparam int unsigned MODE_W = $clog2(NUM_FUNCS);
  localparam int unsigned CNT_W  = (BANNER_CYCLES > 0) ? $clog2(BANNER_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  BANNER_LOAD = (BANNER_CYCLES > 0) ? CNT_W'(BANNER_CYCLES - 1) : '0;
  localparam logic [MODE_W-1:0] LAST_IDX    = MODE_W'(NUM_FUNCS - 1);

  typedef enum logic [1:0] {ACTIVE, SEARCH, BANNER} stateT;

  stateT                state, stateNext;
  logic [MODE_W-1:0]    mode, modeNext;
  logic [MODE_W-1:0]    cand, candNext;
  logic                 dirFwd, dirNext;
  logic [CNT_W-1:0]     cnt, cntNext;
  logic [NUM_FUNCS-1:0] funcEnable, enableNext;
  logic                 modeChange, changeNext;
  logic                 availMode, availCand;
  logic                 reqNext, reqPrev;
  logic [DISP_W-1:0]    dispArr [NUM_FUNCS];
  logic [LED_W-1:0]     ledArr  [NUM_FUNCS];

  // Modular step of a function index in either direction.
  function automatic logic [MODE_W-1:0] stepIdx(input logic [MODE_W-1:0] idx, input logic fwd);
    if (fwd) return (idx == LAST_IDX) ? '0 : idx + MODE_W'(1);
    else     return (idx == '0) ? LAST_IDX : idx - MODE_W'(1);
  endfunction

  for (genvar g = 0; g < NUM_FUNCS; g++) begin : gSlice
    assign dispArr[g] = bus.functionDisplays[g*DISP_W +: DISP_W];
    assign ledArr[g]  = bus.functionLEDs[g*LED_W +: LED_W];
  end

  assign availMode = bus.funcAvail[mode];
  assign availCand = bus.funcAvail[cand];
  // Simultaneous next/prev cancel each other.
  assign reqNext   = bus.nextFunc & ~bus.prevFunc;
  assign reqPrev   = bus.prevFunc & ~bus.nextFunc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      mode       <= '0;
      cand       <= '0;
      dirFwd     <= 1'b1;
      cnt        <= '0;
      funcEnable <= '0;
      modeChange <= 1'b0;
    end else begin
      state      <= stateNext;
      mode       <= modeNext;
      cand       <= candNext;
      dirFwd     <= dirNext;
      cnt        <= cntNext;
      funcEnable <= enableNext;
      modeChange <= changeNext;
    end
  end

  always_comb begin
    stateNext  = state;
    modeNext   = mode;
    candNext   = cand;
    dirNext    = dirFwd;
    cntNext    = cnt;
    changeNext = 1'b0;
    enableNext = '0;
    unique case (state)
      ACTIVE: begin
        // Losing the active function forces a forward search.
        if (!availMode || reqNext) begin
          stateNext = SEARCH;
          candNext  = stepIdx(mode, 1'b1);
          dirNext   = 1'b1;
        end else if (reqPrev) begin
          stateNext = SEARCH;
          candNext  = stepIdx(mode, 1'b0);
          dirNext   = 1'b0;
        end
      end
      SEARCH: begin
        if (availCand && (cand != mode)) begin
          modeNext   = cand;
          changeNext = 1'b1;
          if (BANNER_CYCLES == 0) begin
            stateNext = ACTIVE;
          end else begin
            stateNext = BANNER;
            cntNext   = BANNER_LOAD;
          end
        end else if (availCand) begin
          stateNext = ACTIVE;
        end else begin
          // Keeps rotating even when nothing is available, so recovery is automatic.
          candNext = stepIdx(cand, dirFwd);
        end
      end
      BANNER: begin
        if (reqNext || reqPrev) begin
          stateNext = SEARCH;
          candNext  = stepIdx(mode, reqNext);
          dirNext   = reqNext;
        end else if (cnt == '0) begin
          stateNext = ACTIVE;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      default: stateNext = SEARCH;
    endcase
    if (stateNext == ACTIVE) enableNext = NUM_FUNCS'(1) << modeNext;
  end

  // Same-cycle routing of keys and display/LED words.
  always_comb begin
    bus.funcKey = '0;
    bus.wordBus = '0;
    bus.led     = '0;
    if (state == ACTIVE) begin
      bus.funcKey = bus.keyPulse;
      bus.wordBus = dispArr[mode];
      bus.led     = ledArr[mode];
    end else if (state == BANNER) begin
      bus.wordBus = DISP_W'(mode);
      bus.led     = LED_W'(1) << mode;
    end
  end

  assign bus.mode       = mode;
  assign bus.funcEnable = funcEnable;
  assign bus.modeChange = modeChange;
endmodule

// File: tb/tb_function_mode_sequencer.sv
// Randomized bench for function_mode_sequencer against a transaction-level model of
// target selection, skip latency and banner length.
module tb_function_mode_sequencer;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int KW = 8;
  localparam int B  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mMode = 0;
  bit   mInBanner = 1'b0;
  logic [DW-1:0] dispWords [N];
  logic [LW-1:0] ledWords  [N];

  function_mode_sequencer_if #(.NUM_FUNCS(N), .DISP_W(DW), .LED_W(LW), .KEY_W(KW)) bus ();

  function_mode_sequencer #(
    .NUM_FUNCS(N), .DISP_W(DW), .LED_W(LW), .KEY_W(KW), .BANNER_CYCLES(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ix(input int v);
    return 2'(v);
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic randWords();
    for (int i = 0; i < N; i++) begin
      dispWords[i] = $urandom;
      ledWords[i]  = LW'($urandom);
    end
    bus.functionDisplays = {dispWords[3], dispWords[2], dispWords[1], dispWords[0]};
    bus.functionLEDs     = {ledWords[3], ledWords[2], ledWords[1], ledWords[0]};
  endtask

  task automatic randKey();
    bus.keyPulse = KW'($urandom_range(1, 255));
  endtask

  task automatic checkActive(input string tag, input int m);
    checkEq({tag, "_mode"}, 32'(bus.mode), 32'(m));
    checkEq({tag, "_en"},   32'(bus.funcEnable), 32'(1) << m);
    checkEq({tag, "_key"},  32'(bus.funcKey), 32'(bus.keyPulse));
    checkEq({tag, "_word"}, 32'(bus.wordBus), 32'(dispWords[ix(m)]));
    checkEq({tag, "_led"},  32'(bus.led), 32'(ledWords[ix(m)]));
  endtask

  // Async reset check, release, then expect function 0 enabled one edge later.
  task automatic doReset();
    bus.funcAvail = 4'hF;
    bus.nextFunc  = 1'b0;
    bus.prevFunc  = 1'b0;
    randKey();
    rst = 1'b1;
    #1;
    checkEq("rst_mode", 32'(bus.mode), 0);
    checkEq("rst_en",   32'(bus.funcEnable), 0);
    checkEq("rst_key",  32'(bus.funcKey), 0);
    checkEq("rst_chg",  32'(bus.modeChange), 0);
    checkEq("rst_word", 32'(bus.wordBus), 0);
    checkEq("rst_led",  32'(bus.led), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkEq("rel_en", 32'(bus.funcEnable), 0);
    @(posedge clk); #1;
    randKey();
    @(negedge clk);
    checkActive("boot", 0);
    @(posedge clk); #1;
    mMode = 0;
    mInBanner = 1'b0;
  endtask

  // kind 0 = next, 1 = prev, 2 = drop availability of the active function.
  // partial stops checking at the first banner cycle, leaving the DUT in BANNER.
  task automatic doRequest(input int kind, input logic [3:0] avail, input bit partial);
    bit fwd, found, changed;
    int target, k, last, c;
    fwd = (kind != 1);
    found = 1'b0;
    target = mMode;
    k = 0;
    for (int s = 1; s <= N; s++) begin
      c = fwd ? (mMode + s) % N : (mMode - s + N) % N;
      if (!found && avail[ix(c)]) begin
        found = 1'b1;
        target = c;
        k = s - 1;
      end
    end
    changed = (target != mMode);
    last = (changed && !partial) ? 1 + k + B : 1 + k;
    randWords();
    bus.funcAvail = avail;
    bus.nextFunc  = (kind == 0);
    bus.prevFunc  = (kind == 1);
    randKey();
    @(posedge clk); #1;
    bus.nextFunc = 1'b0;
    bus.prevFunc = 1'b0;
    randKey();
    for (int cyc = 0; cyc <= last; cyc++) begin
      @(negedge clk);
      if (cyc < 1 + k) begin
        checkEq("srch_mode", 32'(bus.mode), 32'(mMode));
        checkEq("srch_en",   32'(bus.funcEnable), 0);
        checkEq("srch_chg",  32'(bus.modeChange), 0);
        checkEq("srch_key",  32'(bus.funcKey), 0);
      end else if (changed && cyc < 1 + k + B) begin
        checkEq("ban_mode", 32'(bus.mode), 32'(target));
        checkEq("ban_chg",  32'(bus.modeChange), 32'(cyc == 1 + k));
        checkEq("ban_en",   32'(bus.funcEnable), 0);
        checkEq("ban_key",  32'(bus.funcKey), 0);
        checkEq("ban_word", 32'(bus.wordBus), 32'(target));
        checkEq("ban_led",  32'(bus.led), 32'(1) << target);
      end else begin
        checkActive("act", target);
        checkEq("act_chg", 32'(bus.modeChange), 0);
      end
      if (cyc < last) begin
        @(posedge clk); #1;
        randKey();
      end
    end
    @(posedge clk); #1;
    mMode = target;
    mInBanner = changed && partial;
  endtask

  initial begin
    bus.nextFunc  = 1'b0;
    bus.prevFunc  = 1'b0;
    bus.funcAvail = 4'hF;
    bus.keyPulse  = '0;
    randWords();
    #2;
    doReset();

    // Forward wrap 1,2,3,0 then reverse wrap to 3.
    repeat (4) doRequest(0, 4'hF, 1'b0);
    doRequest(1, 4'hF, 1'b0);

    // Skip an unavailable function: 1 -> 3 with function 2 off.
    doRequest(0, 4'hF, 1'b0);
    doRequest(0, 4'hF, 1'b0);
    doRequest(0, 4'b1011, 1'b0);

    // Key gating in ACTIVE and during the banner.
    doRequest(1, 4'hF, 1'b0);
    bus.keyPulse = 8'h1C;
    #1;
    checkEq("key_act", 32'(bus.funcKey), 32'h1C);
    checkEq("key_act_en", 32'(bus.funcEnable), 32'b0100);
    doRequest(0, 4'hF, 1'b1);
    bus.keyPulse = 8'h1C;
    #1;
    checkEq("key_ban", 32'(bus.funcKey), 0);
    checkEq("key_ban_en", 32'(bus.funcEnable), 0);
    doRequest(1, 4'hF, 1'b0);

    // Simultaneous next and prev are ignored.
    bus.nextFunc = 1'b1;
    bus.prevFunc = 1'b1;
    @(posedge clk); #1;
    bus.nextFunc = 1'b0;
    bus.prevFunc = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkEq("both_mode", 32'(bus.mode), 32'(mMode));
      checkEq("both_en",   32'(bus.funcEnable), 32'(1) << mMode);
      checkEq("both_chg",  32'(bus.modeChange), 0);
      @(posedge clk); #1;
    end

    // Active function disappears: forced forward search.
    doRequest(2, 4'b1011, 1'b0);

    for (int it = 0; it < 40; it++) begin
      int kind;
      logic [3:0] av;
      bit part;
      kind = mInBanner ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
      if (kind == 2) begin
        av = 4'($urandom_range(1, 15)) & ~(4'(1) << mMode);
        if (av == 4'b0) av = 4'(1) << ((mMode + 1) % N);
      end else begin
        av = 4'($urandom_range(0, 15)) | (4'(1) << mMode);
      end
      part = ($urandom_range(0, 3) == 0);
      doRequest(kind, av, part);
    end
    if (mInBanner) doRequest(0, 4'hF, 1'b0);

    // Nothing available: enable stays low and no mode change is reported.
    bus.funcAvail = 4'b0000;
    repeat (12) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkEq("none_en",   32'(bus.funcEnable), 0);
      checkEq("none_chg",  32'(bus.modeChange), 0);
      checkEq("none_mode", 32'(bus.mode), 32'(mMode));
    end
    @(posedge clk); #1;
    doReset();

    // Reset in the middle of a banner, then a normal restart.
    doRequest(0, 4'hF, 1'b0);
    doRequest(0, 4'hF, 1'b1);
    doReset();
    doRequest(1, 4'hF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
